startup_display_seq: RTL and testbench

Parametrised, optionally triplicated startup display sequencer. After RUN it steps a pattern address through NPAT display patterns and holds each pattern for a programmable dwell. The dwell timer and address counter are internal. It sits between the board startup controller and the front-panel/LED pattern ROM, replacing the fixed 3000-cycle, externally timed sequencer. It adds loop mode, hold, abort and an SEU flag.

---
 rtl/startup_disp_pkg.sv | 49 ++++
 rtl/startup_display_seq_vote.sv | 17 +
 rtl/startup_display_seq.sv | 139 +++++++++++++
 tb/tb_startup_display_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/startup_disp_pkg.sv
// Shared types and helpers for the startup display sequencer: state encoding,
// bitwise majority vote and the state-to-output decode.
package startup_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_NEXT = 3'd3,
    S_SKIP = 3'd4,
    S_END  = 3'd5
  } state_t;

  localparam int MAJ_W = 32;
  localparam int OUT_W = 6;

  typedef struct packed {
    logic clear;
    logic disp;
    logic load_pat;
    logic nxt_adr;
    logic busy;
    logic fin;
  } out_t;

  // Callers zero-extend narrower operands to MAJ_W and truncate the result.
  function automatic logic [MAJ_W-1:0] maj3(input logic [MAJ_W-1:0] a,
                                            input logic [MAJ_W-1:0] b,
                                            input logic [MAJ_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic out_t decode_out(input state_t s);
    out_t o;
    o      = '0;
    o.disp = 1'b1;
    case (s)
      S_IDLE: begin o.clear = 1'b1; o.disp = 1'b0; end
      S_LOAD: begin o.load_pat = 1'b1; o.busy = 1'b1; end
      S_WAIT: o.busy = 1'b1;
      S_NEXT: begin o.nxt_adr = 1'b1; o.busy = 1'b1; end
      S_SKIP: o.busy = 1'b1;
      S_END:  begin o.clear = 1'b1; o.disp = 1'b0; o.fin = 1'b1; end
      default: begin o.clear = 1'b1; o.disp = 1'b0; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/startup_display_seq_vote.sv
// tmr_vote: bitwise 2-of-3 majority over three W-bit replicas (W <= 32) with a
// disagreement flag.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic         mismatch
);
  import startup_disp_pkg::*;

  assign y        = W'(maj3(MAJ_W'(a), MAJ_W'(b), MAJ_W'(c)));
  assign mismatch = (a != b) || (a != c);

endmodule

// File: rtl/startup_display_seq.sv
// Startup display sequencer: steps ADR through NPAT patterns with a DWELL-cycle hold each.
// Define STARTUP_DISP_TMR_EN to triplicate state/timer/ADR/output registers with voting.
module startup_display_seq #(
  parameter int NPAT  = 8,
  parameter int DWELL = 3000,
  parameter int LOOP  = 0,
  parameter int ADR_W = (NPAT > 1) ? $clog2(NPAT) : 1,
  parameter int TW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             HOLD,
  input  logic             ABORT,
  output logic [ADR_W-1:0] ADR,
  output logic             LOAD_PAT,
  output logic             NXT_ADR,
  output logic             CLEAR,
  output logic             DISP,
  output logic             BUSY,
  output logic             FIN,
  output logic             SEU_ERR
);
  import startup_disp_pkg::*;

  localparam logic [TW-1:0]    TMR_LAST = TW'(DWELL - 1);
  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(NPAT - 1);

  state_t             st_v, st_n;
  logic [TW-1:0]      tmr_v, tmr_n;
  logic [ADR_W-1:0]   adr_v, adr_n;
  logic [OUT_W-1:0]   out_v, out_n;

  always_comb begin
    st_n  = S_IDLE;
    adr_n = adr_v;
    if (ABORT) begin
      st_n  = S_IDLE;
      adr_n = '0;
    end else begin
      case (st_v)
        S_IDLE: if (RUN) begin
          st_n  = S_LOAD;
          adr_n = '0;
        end
        S_LOAD: st_n = S_WAIT;
        S_WAIT: begin
          if (HOLD || tmr_v != TMR_LAST) begin
            st_n = S_WAIT;
          end else if (adr_v != ADR_LAST || LOOP != 0) begin
            st_n  = S_NEXT;
            adr_n = (adr_v == ADR_LAST) ? '0 : adr_v + ADR_W'(1);
          end else begin
            st_n = S_END;
          end
        end
        S_NEXT: st_n = S_SKIP;
        S_SKIP: st_n = S_LOAD;
        S_END:  st_n = RUN ? S_END : S_IDLE;
        default: st_n = S_IDLE;
      endcase
    end

    if (st_v == S_WAIT && st_n == S_WAIT) tmr_n = HOLD ? tmr_v : tmr_v + TW'(1);
    else                                  tmr_n = '0;

    out_n = decode_out(st_n);
  end

`ifdef STARTUP_DISP_TMR_EN
  (* keep = "true", preserve = "true" *) logic [2:0][2:0]       st_q;
  (* keep = "true", preserve = "true" *) logic [2:0][TW-1:0]    tmr_q;
  (* keep = "true", preserve = "true" *) logic [2:0][ADR_W-1:0] adr_q;
  (* keep = "true", preserve = "true" *) logic [2:0][OUT_W-1:0] out_q;
  logic [2:0] st_vote;
  logic       mm_st, mm_tmr, mm_adr, seu_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= S_IDLE;
        tmr_q[i] <= '0;
        adr_q[i] <= '0;
        out_q[i] <= decode_out(S_IDLE);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_n;
        tmr_q[i] <= tmr_n;
        adr_q[i] <= adr_n;
        out_q[i] <= out_n;
      end
    end
  end

  tmr_vote #(.W(3))     u_vote_st  (.a(st_q[0]),  .b(st_q[1]),  .c(st_q[2]),  .y(st_vote), .mismatch(mm_st));
  tmr_vote #(.W(TW))    u_vote_tmr (.a(tmr_q[0]), .b(tmr_q[1]), .c(tmr_q[2]), .y(tmr_v),   .mismatch(mm_tmr));
  tmr_vote #(.W(ADR_W)) u_vote_adr (.a(adr_q[0]), .b(adr_q[1]), .c(adr_q[2]), .y(adr_v),   .mismatch(mm_adr));

  assign st_v  = state_t'(st_vote);
  assign out_v = OUT_W'(maj3(MAJ_W'(out_q[0]), MAJ_W'(out_q[1]), MAJ_W'(out_q[2])));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          seu_q <= 1'b0;
    else if (mm_st || mm_tmr || mm_adr) seu_q <= 1'b1;
  end

  assign SEU_ERR = seu_q;
`else
  state_t           st_q;
  logic [TW-1:0]    tmr_q;
  logic [ADR_W-1:0] adr_q;
  logic [OUT_W-1:0] out_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q  <= S_IDLE;
      tmr_q <= '0;
      adr_q <= '0;
      out_q <= decode_out(S_IDLE);
    end else begin
      st_q  <= st_n;
      tmr_q <= tmr_n;
      adr_q <= adr_n;
      out_q <= out_n;
    end
  end

  assign st_v    = st_q;
  assign tmr_v   = tmr_q;
  assign adr_v   = adr_q;
  assign out_v   = out_q;
  assign SEU_ERR = 1'b0;
`endif

  assign ADR = adr_v;
  assign {CLEAR, DISP, LOAD_PAT, NXT_ADR, BUSY, FIN} = out_v;

endmodule

// File: tb/tb_startup_display_seq.sv
// Bench for startup_display_seq: three configurations share stimulus and are compared each
// cycle against a pattern/position reference model, plus directed timing checks.
module tb_startup_display_seq;

  logic       CLK = 1'b0, RST = 1'b1, RUN = 1'b0, HOLD = 1'b0, ABORT = 1'b0;
  logic [1:0] adr0, adr1;
  logic [0:0] adr2;
  logic [2:0] ld, nx, cl, ds, bz, fn, se;

  always #5 CLK = ~CLK;

  startup_display_seq #(.NPAT(3), .DWELL(4), .LOOP(0)) d0 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .HOLD(HOLD), .ABORT(ABORT), .ADR(adr0),
    .LOAD_PAT(ld[0]), .NXT_ADR(nx[0]), .CLEAR(cl[0]), .DISP(ds[0]), .BUSY(bz[0]),
    .FIN(fn[0]), .SEU_ERR(se[0]));
  startup_display_seq #(.NPAT(3), .DWELL(4), .LOOP(1)) d1 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .HOLD(HOLD), .ABORT(ABORT), .ADR(adr1),
    .LOAD_PAT(ld[1]), .NXT_ADR(nx[1]), .CLEAR(cl[1]), .DISP(ds[1]), .BUSY(bz[1]),
    .FIN(fn[1]), .SEU_ERR(se[1]));
  startup_display_seq #(.NPAT(1), .DWELL(2), .LOOP(1)) d2 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .HOLD(HOLD), .ABORT(ABORT), .ADR(adr2),
    .LOAD_PAT(ld[2]), .NXT_ADR(nx[2]), .CLEAR(cl[2]), .DISP(ds[2]), .BUSY(bz[2]),
    .FIN(fn[2]), .SEU_ERR(se[2]));

  // Model: pattern index plus position within the pattern period
  // (0 = load, 1..DWELL = dwell cycles, DWELL+1 = advance, DWELL+2 = settle).
  int np[3] = '{3, 3, 1};
  int dw[3] = '{4, 4, 2};
  int lp[3] = '{0, 1, 1};
  int m_pat[3], m_pos[3];
  bit m_act[3], m_fin[3], m_seu[3];

  int errors = 0, checks = 0, c = 0;
  int ld0_c[$], ld0_a[$], nx0_c[$], ld1_c[$], nx1_c[$];
  int fin0 = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 0; m_fin[k] = 0; m_pat[k] = 0; m_pos[k] = 0; m_seu[k] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      if (ABORT) begin
        m_act[k] = 0; m_fin[k] = 0; m_pat[k] = 0; m_pos[k] = 0;
      end else if (m_fin[k]) begin
        if (!RUN) m_fin[k] = 0;
      end else if (!m_act[k]) begin
        if (RUN) begin m_act[k] = 1; m_pat[k] = 0; m_pos[k] = 0; end
      end else if (m_pos[k] >= 1 && m_pos[k] <= dw[k] && HOLD) begin
        m_pos[k] = m_pos[k];
      end else if (m_pos[k] == dw[k]) begin
        if (m_pat[k] == np[k] - 1 && lp[k] == 0) begin
          m_act[k] = 0; m_fin[k] = 1;
        end else begin
          m_pos[k] = dw[k] + 1;
          m_pat[k] = (m_pat[k] + 1) % np[k];
        end
      end else if (m_pos[k] == dw[k] + 2) begin
        m_pos[k] = 0;
      end else begin
        m_pos[k]++;
      end
    end
  endfunction

  // {adr[7:0], clear, disp, load_pat, nxt_adr, busy, fin, seu_err}
  function automatic logic [31:0] exp_vec(input int k);
    logic [31:0] v;
    v       = '0;
    v[14:7] = 8'(m_pat[k]);
    v[6]    = !m_act[k];
    v[5]    = m_act[k];
    v[4]    = m_act[k] && m_pos[k] == 0;
    v[3]    = m_act[k] && m_pos[k] == dw[k] + 1;
    v[2]    = m_act[k];
    v[1]    = m_fin[k];
    v[0]    = m_seu[k];
    return v;
  endfunction

  function automatic logic [31:0] got_vec(input int k);
    logic [31:0] v;
    v = '0;
    case (k)
      0:       v[14:7] = 8'(adr0);
      1:       v[14:7] = 8'(adr1);
      default: v[14:7] = 8'(adr2);
    endcase
    v[6:0] = {cl[k], ds[k], ld[k], nx[k], bz[k], fn[k], se[k]};
    return v;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    c = 0; fin0 = -1;
    ld0_c.delete(); ld0_a.delete(); nx0_c.delete(); ld1_c.delete(); nx1_c.delete();
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_step();
    c++;
    @(negedge CLK);
    for (int k = 0; k < 3; k++)
      check_val($sformatf("cyc%0d_d%0d", c, k), got_vec(k), exp_vec(k));
    if (ld[0]) begin ld0_c.push_back(c); ld0_a.push_back(int'(adr0)); end
    if (nx[0]) nx0_c.push_back(c);
    if (ld[1]) ld1_c.push_back(c);
    if (nx[1]) nx1_c.push_back(c);
    if (fn[0] && fin0 < 0) fin0 = c;
  endtask

  // Called at a negedge: asynchronous reset pulse that never spans a clock edge.
  task automatic async_reset();
    #1 RST = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) check_val($sformatf("rst_d%0d", k), got_vec(k), 32'h40);
    #1 RST = 1'b0;
  endtask

  task automatic seq_timing(input string p);
    check_val({p, "_ld0"}, qget(ld0_c, 0), 1);
    check_val({p, "_ld1"}, qget(ld0_c, 1), 8);
    check_val({p, "_ld2"}, qget(ld0_c, 2), 15);
    check_val({p, "_adr1"}, qget(ld0_a, 1), 1);
    check_val({p, "_adr2"}, qget(ld0_a, 2), 2);
    check_val({p, "_nx0"}, qget(nx0_c, 0), 6);
    check_val({p, "_nx1"}, qget(nx0_c, 1), 13);
    check_val({p, "_fin"}, fin0, 20);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 3; k++) check_val($sformatf("por_d%0d", k), got_vec(k), 32'h40);
    #1 RST = 1'b0;
    @(negedge CLK);

    // Basic run: stop in End without loop, three wraps with loop.
    RUN = 1'b1; clear_log();
    repeat (70) tick();
    seq_timing("s1");
    check_val("loop_nx_wrap", qget(nx1_c, 2), 20);
    check_val("loop_ld_wrap", qget(ld1_c, 3), 22);
    check_val("loop_nloads", ld1_c.size(), 10);
    RUN = 1'b0;
    repeat (2) tick();

    // Abort coinciding with the dwell exit.
    ABORT = 1'b1; tick(); ABORT = 1'b0; tick();
    RUN = 1'b1; clear_log();
    repeat (5) tick();
    ABORT = 1'b1; tick();
    check_val("abort_nxt", nx[0], 0);
    check_val("abort_busy", bz[0], 0);
    check_val("abort_adr", adr0, 0);
    ABORT = 1'b0; clear_log(); tick();
    check_val("restart_ld", ld[0], 1);
    check_val("restart_adr", adr0, 0);

    // Hold for five cycles mid-dwell, then reset during the settle cycle.
    repeat (2) tick();
    HOLD = 1'b1; repeat (5) tick();
    HOLD = 1'b0; repeat (4) tick();
    check_val("hold_nx", qget(nx0_c, 0), 11);
    async_reset();
    clear_log();
    repeat (22) tick();
    seq_timing("s2");

    // Randomised stimulus with occasional asynchronous resets.
    for (int blk = 0; blk < 30; blk++) begin
      int run_bias = $urandom_range(1, 9);
      for (int i = 0; i < 100; i++) begin
        RUN   = ($urandom_range(0, 9) < run_bias);
        HOLD  = ($urandom_range(0, 3) == 0);
        ABORT = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 299) == 0) async_reset();
        tick();
      end
    end

`ifdef STARTUP_DISP_TMR_EN
    ABORT = 1'b0; HOLD = 1'b0; RUN = 1'b1;
    async_reset();
    repeat (3) tick();
    force d0.st_q[1] = 3'd5;
    #1 release d0.st_q[1];
    m_seu[0] = 1'b1;
    repeat (25) tick();
    check_val("seu_sticky", se[0], 1);
`endif
    async_reset();
    RUN = 1'b0; ABORT = 1'b0; HOLD = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
